// File: rtl/mon_prod_radix.sv
// rtl/mon_prod_radix.sv - radix-2^RADIX_BITS Montgomery multiplier, P = A*B*R^-N mod M
//
// Purpose: digit-serial Montgomery product for the RSA datapath. One radix-R
// digit of B is consumed per clock. mu = -M^-1 mod R is derived bit-serially
// from the low digit of M before the digit loop starts.
//
// Optional feature macro: MON_PROD_FINAL_SUB_EN
//   defined   - one extra SUB cycle, P fully reduced (0 <= P < M)
//   undefined - no SUB cycle, P = P_acc truncated (0 <= P < 2M, 2M <= 2^BIT_LEN required)
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   start      in   operation request, sampled only in IDLE
//   A          in   multiplicand (A < M)
//   B          in   multiplier, least significant digit first
//   M          in   modulus (must be odd)
//   num_digits in   number of B digits to process
//   busy       out  high from start acceptance until done
//   done       out  one-cycle completion pulse
//   err        out  set with done when M was even
//   P          out  result, held until next accepted start

module mon_prod_radix #(
  parameter int BIT_LEN     = 64,
  parameter int RADIX_BITS  = 2,
  parameter int COUNT_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [BIT_LEN-1:0]     A,
  input  logic [BIT_LEN-1:0]     B,
  input  logic [BIT_LEN-1:0]     M,
  input  logic [COUNT_WIDTH-1:0] num_digits,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [BIT_LEN-1:0]     P
);

  localparam int PW = BIT_LEN + 2;
  localparam int SW = BIT_LEN + RADIX_BITS + 2;
  localparam int KW = (RADIX_BITS > 1) ? $clog2(RADIX_BITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MU,
    S_CALC,
    S_SUB,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [BIT_LEN-1:0]     a_q, a_d;
  logic [BIT_LEN-1:0]     b_q, b_d;
  logic [BIT_LEN-1:0]     m_q, m_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]          pacc_q, pacc_d;
  logic [RADIX_BITS-1:0]  x_q, x_d;
  logic [KW-1:0]          k_q, k_d;
  logic [RADIX_BITS-1:0]  mu_q, mu_d;
  logic [BIT_LEN-1:0]     p_q, p_d;
  logic                   err_q, err_d;

  // mu derivation: x converges to M^-1 mod R one bit per cycle. Bit k of
  // m0*x is wrong exactly when x is missing 2^k, and since x < 2^k the add is
  // a plain bit set.
  logic [RADIX_BITS-1:0] m0x, m0x_sh, x_next;

  always_comb begin
    m0x    = m_q[RADIX_BITS-1:0] * x_q;
    m0x_sh = m0x >> k_q;
    x_next = m0x_sh[0] ? (x_q | (RADIX_BITS'(1) << k_q)) : x_q;
  end

  // Digit step: q makes the low digit of the sum vanish, so the shift is exact.
  logic [RADIX_BITS-1:0] bt, q;
  logic [SW-1:0]         ab, mq, sum;
  logic [PW-1:0]         pacc_next;

  always_comb begin
    bt        = b_q[RADIX_BITS-1:0];
    q         = (pacc_q[RADIX_BITS-1:0] + a_q[RADIX_BITS-1:0] * bt) * mu_q;
    ab        = SW'(a_q) * SW'(bt);
    mq        = SW'(m_q) * SW'(q);
    sum       = SW'(pacc_q) + ab + mq;
    pacc_next = PW'(sum >> RADIX_BITS);
  end

`ifdef MON_PROD_FINAL_SUB_EN
  logic [PW-1:0]      pacc_diff;
  logic [BIT_LEN-1:0] pacc_red;

  always_comb begin
    pacc_diff = pacc_q - PW'(m_q);
    pacc_red  = (pacc_q >= PW'(m_q)) ? pacc_diff[BIT_LEN-1:0] : pacc_q[BIT_LEN-1:0];
  end
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    pacc_d  = pacc_q;
    x_d     = x_q;
    k_d     = k_q;
    mu_d    = mu_q;
    p_d     = p_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d    = A;
          b_d    = B;
          m_d    = M;
          cnt_d  = num_digits;
          pacc_d = '0;
          p_d    = '0;
          err_d  = 1'b0;
          x_d    = RADIX_BITS'(1);
          k_d    = KW'(1);
          if (!M[0]) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (num_digits == '0) begin
            state_d = S_DONE;
          end else if (RADIX_BITS == 1) begin
            mu_d    = RADIX_BITS'(1);
            state_d = S_CALC;
          end else begin
            state_d = S_MU;
          end
        end
      end

      S_MU: begin
        x_d = x_next;
        k_d = k_q + KW'(1);
        if (k_q == KW'(RADIX_BITS - 1)) begin
          mu_d    = RADIX_BITS'(0) - x_next;
          state_d = S_CALC;
        end
      end

      S_CALC: begin
        pacc_d = pacc_next;
        b_d    = b_q >> RADIX_BITS;
        cnt_d  = cnt_q - COUNT_WIDTH'(1);
        if (cnt_q == COUNT_WIDTH'(1)) begin
`ifdef MON_PROD_FINAL_SUB_EN
          state_d = S_SUB;
`else
          p_d     = pacc_next[BIT_LEN-1:0];
          state_d = S_DONE;
`endif
        end
      end

`ifdef MON_PROD_FINAL_SUB_EN
      S_SUB: begin
        p_d     = pacc_red;
        state_d = S_DONE;
      end
`endif

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      pacc_q  <= '0;
      x_q     <= '0;
      k_q     <= '0;
      mu_q    <= '0;
      p_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      pacc_q  <= pacc_d;
      x_q     <= x_d;
      k_q     <= k_d;
      mu_q    <= mu_d;
      p_q     <= p_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done = (state_q == S_DONE);
  assign err  = err_q;
  assign P    = p_q;

endmodule

// File: tb/tb_mon_prod_radix.sv
// tb/tb_mon_prod_radix.sv - self-checking bench for mon_prod_radix (BIT_LEN=8, RADIX_BITS=2)

module tb_mon_prod_radix;

  localparam int BL = 8;
  localparam int RB = 2;
  localparam int CW = 6;
`ifdef MON_PROD_FINAL_SUB_EN
  localparam int SUB_LAT  = 1;
  localparam bit FULL_RED = 1'b1;
`else
  localparam int SUB_LAT  = 0;
  localparam bit FULL_RED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [BL-1:0] a = '0;
  logic [BL-1:0] b = '0;
  logic [BL-1:0] m = '0;
  logic [CW-1:0] nd = '0;
  logic          busy, done, err;
  logic [BL-1:0] p;

  int total = 0;
  int bad   = 0;

  mon_prod_radix #(.BIT_LEN(BL), .RADIX_BITS(RB), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .A(a), .B(b), .M(m), .num_digits(nd),
    .busy(busy), .done(done), .err(err), .P(p)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int m;
    int nd;
    int exp_p;
    bit exp_err;
    bit guard;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Without the final subtraction the result may sit one modulus high.
  task automatic check_p(input string name, input int act, input int exp, input int mod, input bit exact);
    bit ok;
    total++;
    ok = (act == exp) || (!FULL_RED && !exact && act == exp + mod);
    if (!ok) begin
      bad++;
      $display("FAIL %s: got P=%0d expected %0d (mod %0d)", name, act, exp, mod);
    end
  endtask

  function automatic int lat_of(input int n, input bit guard);
    return guard ? 0 : RB + n - 1 + SUB_LAT;
  endfunction

  // Reference: solve x * 2^(2n) == A * (B mod 2^(2n)) (mod M) by search.
  function automatic int ref_mont(input int ra, input int rb, input int rm, input int rn);
    int bm, prod, rr, res;
    bm   = rb & ((1 << (2 * rn)) - 1);
    prod = (ra * bm) % rm;
    rr   = (1 << (2 * rn)) % rm;
    res  = -1;
    for (int x = rm - 1; x >= 0; x--)
      if ((x * rr) % rm == prod) res = x;
    return res;
  endfunction

  // Latency counts edges after the one that samples start.
  task automatic run_op(input int ta, input int tb, input int tm, input int tn,
                        output int rp, output int rerr, output int rlat,
                        output bit busy_ok, output bit pulse_ok);
    @(negedge clk);
    a = BL'(ta); b = BL'(tb); m = BL'(tm); nd = CW'(tn); start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    rlat = 0;
    busy_ok = 1'b1;
    while (!done && rlat < 200) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      rlat++;
    end
    if (!done) rlat = -1;
    rp   = int'(p);
    rerr = int'(err);
    if (busy) busy_ok = 1'b0;
    @(posedge clk);
    #1;
    pulse_ok = !done;
  endtask

  initial begin
    int rp, rerr, rlat, dones, first_lat, p_at_done;
    bit busy_ok, pulse_ok, saw_done;

    tbl[0]  = '{5,   7,   11,  4, 8,  1'b0, 1'b0};
    tbl[1]  = '{12,  12,  13,  4, 3,  1'b0, 1'b0};
    tbl[2]  = '{0,   200, 11,  4, 0,  1'b0, 1'b0};
    tbl[3]  = '{3,   4,   10,  4, 0,  1'b1, 1'b1};
    tbl[4]  = '{5,   7,   11,  4, 8,  1'b0, 1'b0};
    tbl[5]  = '{5,   7,   11,  0, 0,  1'b0, 1'b1};
    tbl[6]  = '{10,  255, 11,  4, 3,  1'b0, 1'b0};
    tbl[7]  = '{5,   7,   11,  6, 6,  1'b0, 1'b0};
    tbl[8]  = '{7,   3,   13,  1, 2,  1'b0, 1'b0};
    tbl[9]  = '{126, 255, 127, 4, 63, 1'b0, 1'b0};
    tbl[10] = '{2,   1,   3,   4, 2,  1'b0, 1'b0};

    #3;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_err",  int'(err),  0);
    check("reset_p",    int'(p),    0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].nd, rp, rerr, rlat, busy_ok, pulse_ok);
      check_p($sformatf("vec%0d_p", i), rp, tbl[i].exp_p, tbl[i].m, tbl[i].guard);
      check($sformatf("vec%0d_err", i), rerr, int'(tbl[i].exp_err));
      check($sformatf("vec%0d_latency", i), rlat, lat_of(tbl[i].nd, tbl[i].guard));
      check($sformatf("vec%0d_busy", i), int'(busy_ok), 1);
      check($sformatf("vec%0d_done_pulse", i), int'(pulse_ok), 1);
    end

    // Async reset while idle clears held P and err without a clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("idle_reset_p", int'(p), 0);
    @(negedge clk);
    rst = 1'b0;

    run_op(12, 12, 13, 4, rp, rerr, rlat, busy_ok, pulse_ok);
    check("mu_m13", int'(dut.mu_q), 3);
    run_op(5, 7, 11, 4, rp, rerr, rlat, busy_ok, pulse_ok);
    check("mu_m11", int'(dut.mu_q), 1);

    // Second start and input changes while busy must not disturb the run.
    @(negedge clk);
    a = 8'd5; b = 8'd7; m = 8'd11; nd = 6'd4; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dones = 0; first_lat = -1; p_at_done = -1;
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      if (e == 2) begin start = 1'b1; a = 8'd3; b = 8'd99; m = 8'd13; end
      if (e == 3) start = 1'b0;
      @(posedge clk);
      #1;
      if (done) begin
        dones++;
        if (first_lat < 0) begin first_lat = e; p_at_done = int'(p); end
      end
    end
    check("busy_start_dones", dones, 1);
    check("busy_start_latency", first_lat, lat_of(4, 1'b0));
    check_p("busy_start_p", p_at_done, 8, 11, 1'b0);

    // Reset in the middle of CALC abandons the operation.
    @(negedge clk);
    a = 8'd5; b = 8'd7; m = 8'd11; nd = 6'd4; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("calc_reset_busy", int'(busy), 0);
    check("calc_reset_done", int'(done), 0);
    check("calc_reset_p",    int'(p),    0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    check("calc_reset_no_done", int'(saw_done), 0);
    run_op(5, 7, 11, 4, rp, rerr, rlat, busy_ok, pulse_ok);
    check_p("after_reset_p", rp, 8, 11, 1'b0);
    check("after_reset_latency", rlat, lat_of(4, 1'b0));

    for (int i = 0; i < 1000; i++) begin
      int rm, ra, rb, rn, ex;
      rm = 2 * int'($urandom_range(1, 63)) + 1;
      ra = int'($urandom % rm);
      rb = int'($urandom_range(0, 255));
      rn = int'($urandom_range(1, 6));
      ex = ref_mont(ra, rb, rm, rn);
      run_op(ra, rb, rm, rn, rp, rerr, rlat, busy_ok, pulse_ok);
      check_p($sformatf("rand%0d_p a=%0d b=%0d m=%0d n=%0d", i, ra, rb, rm, rn), rp, ex, rm, 1'b0);
      check($sformatf("rand%0d_latency", i), rlat, lat_of(rn, 1'b0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
